bin_to_bcd_seq: RTL

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 90 +++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary to packed BCD converter, one bit per cycle.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
);
  localparam int CW = $clog2(BIN_W);
  localparam logic [63:0] MAX_MAG = (SIGNED != 0) ? (64'd1 << (BIN_W - 1)) : ((64'd1 << BIN_W) - 64'd1);
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = (p < 64'd1000000000000000000) ? p * 64'd10 : p;
    return p;
  endfunction
  if (pow10(DIGITS) <= MAX_MAG) begin : g_chk
    $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
  end
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t                state;
  logic [BIN_W-1:0]      sr;
  logic [4*DIGITS-1:0]   sc, adj, sc_n;
  logic [CW-1:0]         cnt;
  logic                  sgn, sgn_in;
  logic [BIN_W-1:0]      mag;
  assign sgn_in = (SIGNED != 0) & bin[BIN_W-1];
  assign mag    = sgn_in ? ~bin + 1'b1 : bin;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign adj[4*g +: 4] = (sc[4*g +: 4] >= 4'd5) ? sc[4*g +: 4] + 4'd3 : sc[4*g +: 4];
  end
  assign sc_n = {adj[4*DIGITS-2:0], sr[BIN_W-1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      neg   <= 1'b0;
      sc    <= '0;
      sr    <= '0;
      cnt   <= '0;
      sgn   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sr    <= mag;
          sgn   <= sgn_in;
          sc    <= '0;
          cnt   <= '0;
          state <= SHIFT;
          ready <= 1'b0;
          busy  <= 1'b1;
        end
        SHIFT: begin
          sc  <= sc_n;
          sr  <= {sr[BIN_W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(BIN_W - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            bcd   <= sc_n;
            neg   <= sgn;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
